// File: rtl/operand_sel_pipe.sv
// N-way operand select registered behind a valid/ready handshake with a 2-entry skid buffer.
// Illegal selects produce defined data, a per-beat error flag and a saturating error count.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_EMPTY | no beat held; out_valid low, in_ready high
// S_ONE   | OUT holds a beat; in_ready high
// S_TWO   | OUT and SKID both hold beats; in_ready low
module operand_sel_pipe #(
   parameter int  WIDTH        = 64,
   parameter int  NUM_IN       = 3,
   parameter int  INVALID_HOLD = 0,
   localparam int SEL_W        = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_err,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [15:0]             err_count
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W + 1)'(NUM_IN);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_out_data;
   logic               r_out_err;
   logic [WIDTH-1:0]   r_skid_data;
   logic               r_skid_err;
   logic [WIDTH-1:0]   r_last_good;
   logic [15:0]        r_err_count;

   logic               w_accept;
   logic               w_xfer;
   logic               w_legal;
   logic [WIDTH-1:0]   w_sel_data;
   logic [WIDTH-1:0]   w_new_data;
   logic               w_new_err;
   logic               w_load_out_new;
   logic               w_load_out_skid;
   logic               w_load_skid;

   // Handshake flags come from the state register only, so in_ready has no path from out_ready.
   assign in_ready  = (r_state != S_TWO);
   assign out_valid = (r_state != S_EMPTY);
   assign w_accept  = in_valid & in_ready;
   assign w_xfer    = out_valid & out_ready;
   assign w_legal   = ({1'b0, in_sel} < SEL_LIMIT);

   always_comb begin
      w_sel_data = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (in_sel == SEL_W'(k)) begin
            w_sel_data = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      w_new_err = ~w_legal;
      if (w_legal) begin
         w_new_data = w_sel_data;
      end else if (INVALID_HOLD != 0) begin
         w_new_data = r_last_good;
      end else begin
         w_new_data = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_load_out_new  = 1'b0;
      w_load_out_skid = 1'b0;
      w_load_skid     = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (w_accept) begin
               w_load_out_new = 1'b1;
               w_state_nxt    = S_ONE;
            end
         end
         S_ONE: begin
            if (w_accept && w_xfer) begin
               w_load_out_new = 1'b1;
            end else if (w_accept) begin
               w_load_skid = 1'b1;
               w_state_nxt = S_TWO;
            end else if (w_xfer) begin
               w_state_nxt = S_EMPTY;
            end
         end
         S_TWO: begin
            if (w_xfer) begin
               w_load_out_skid = 1'b1;
               w_state_nxt     = S_ONE;
            end
         end
         default: begin
            w_state_nxt = S_EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_err   <= 1'b0;
         r_skid_data <= '0;
         r_skid_err  <= 1'b0;
         r_last_good <= '0;
         r_err_count <= '0;
      end else begin
         if (w_load_out_new) begin
            r_out_data <= w_new_data;
            r_out_err  <= w_new_err;
         end else if (w_load_out_skid) begin
            r_out_data <= r_skid_data;
            r_out_err  <= r_skid_err;
         end
         if (w_load_skid) begin
            r_skid_data <= w_new_data;
            r_skid_err  <= w_new_err;
         end
         if (w_accept && w_legal) begin
            r_last_good <= w_sel_data;
         end
         if (w_accept && !w_legal && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_err   = r_out_err;
   assign err_count = r_err_count;

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Bench for operand_sel_pipe: two instances (zero-fill and hold-last-good on illegal select)
// driven in lockstep and compared against a queue-based reference model.
module tb_operand_sel_pipe;

   localparam int WIDTH  = 64;
   localparam int NUM_IN = 3;
   localparam int DW     = NUM_IN * WIDTH;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [DW-1:0]    in_data = '0;
   logic [1:0]       in_sel = '0;
   logic             in_valid = 1'b0;
   logic             out_ready = 1'b0;

   logic             in_ready0, in_ready1;
   logic [WIDTH-1:0] out_data0, out_data1;
   logic             out_err0, out_err1;
   logic             out_valid0, out_valid1;
   logic [15:0]      err_count0, err_count1;

   always #5 clk = ~clk;

   operand_sel_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .INVALID_HOLD(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(in_ready0), .out_data(out_data0), .out_err(out_err0), .out_valid(out_valid0),
      .out_ready(out_ready), .err_count(err_count0));

   operand_sel_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .INVALID_HOLD(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(in_ready1), .out_data(out_data1), .out_err(out_err1), .out_valid(out_valid1),
      .out_ready(out_ready), .err_count(err_count1));

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             err;
   } beat_t;

   beat_t            q0[$];
   beat_t            q1[$];
   logic [WIDTH-1:0] m_last_good;
   int               m_errs;
   int               n_cmp = 0;
   int               n_fail = 0;

   localparam logic [DW-1:0] D_ABC = {64'h3333, 64'h2222, 64'h1111};

   function automatic logic [WIDTH-1:0] pick(input logic [DW-1:0] d, input int s);
      return d[s*WIDTH +: WIDTH];
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic model_clear();
      q0.delete();
      q1.delete();
      m_last_good = '0;
      m_errs      = 0;
   endtask

   // One clock of stimulus; the model advances from its own occupancy, not from DUT outputs.
   task automatic apply(input logic v, input logic [1:0] s, input logic [DW-1:0] d, input logic r);
      bit    acc, xf;
      beat_t b0, b1;
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
      acc = v && (q0.size() < 2);
      xf  = r && (q0.size() > 0);
      @(posedge clk);
      if (xf) begin
         void'(q0.pop_front());
         void'(q1.pop_front());
      end
      if (acc) begin
         if (int'(s) < NUM_IN) begin
            b0 = '{data: pick(d, int'(s)), err: 1'b0};
            b1 = b0;
            m_last_good = pick(d, int'(s));
         end else begin
            b0 = '{data: '0, err: 1'b1};
            b1 = '{data: m_last_good, err: 1'b1};
            if (m_errs < 65535) m_errs++;
         end
         q0.push_back(b0);
         q1.push_back(b1);
      end
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #3;
      n_cmp++;
      if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_hs got vld %b/%b rdy %b/%b exp vld 0/0 rdy 1/1", out_valid0, out_valid1, in_ready0, in_ready1);
      end
      n_cmp++;
      if (out_data0 !== '0 || out_data1 !== '0 || out_err0 !== 1'b0 || out_err1 !== 1'b0 || err_count0 !== 16'd0 || err_count1 !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_vals got %h %h err %b %b cnt %0d %0d exp all zero", out_data0, out_data1, out_err0, out_err1, err_count0, err_count1);
      end
      do_reset();
   endtask

   task automatic test_basic();
      logic [WIDTH-1:0] exp_d;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 2'(i), D_ABC, 1'b1);
         exp_d = 64'h1111 * (i + 1);
         n_cmp++;
         if (out_valid0 !== 1'b1 || out_data0 !== exp_d || out_err0 !== 1'b0 || out_data1 !== exp_d || out_err1 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_sel%0d got vld %b data %h/%h err %b/%b exp 1 %h 0", i, out_valid0, out_data0, out_data1, out_err0, out_err1, exp_d);
         end
      end
      apply(1'b0, 2'd0, D_ABC, 1'b1);
      n_cmp++;
      if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_drain got vld %b/%b exp 0/0", out_valid0, out_valid1);
      end
   endtask

   task automatic test_illegal();
      do_reset();
      apply(1'b1, 2'd1, D_ABC, 1'b1);
      n_cmp++;
      if (out_data0 !== 64'h2222 || out_data1 !== 64'h2222 || out_err0 !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_pre got %h/%h err %b exp 2222 err 0", out_data0, out_data1, out_err0);
      end
      apply(1'b1, 2'd3, D_ABC, 1'b1);
      n_cmp++;
      if (out_valid0 !== 1'b1 || out_data0 !== 64'h0 || out_err0 !== 1'b1 || err_count0 !== 16'd1) begin
         n_fail++;
         $display("FAIL illegal_zero got vld %b data %h err %b cnt %0d exp 1 0 1 1", out_valid0, out_data0, out_err0, err_count0);
      end
      n_cmp++;
      if (out_data1 !== 64'h2222 || out_err1 !== 1'b1 || err_count1 !== 16'd1) begin
         n_fail++;
         $display("FAIL illegal_hold got data %h err %b cnt %0d exp 2222 1 1", out_data1, out_err1, err_count1);
      end
   endtask

   task automatic test_back_to_back_skid();
      logic [DW-1:0] dx, dy, dz;
      dx = {128'd0, 64'hAAAA};
      dy = {128'd0, 64'hBBBB};
      dz = {128'd0, 64'hCCCC};
      do_reset();
      apply(1'b1, 2'd0, dx, 1'b0);
      apply(1'b1, 2'd0, dy, 1'b0);
      n_cmp++;
      if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0 || out_data0 !== 64'hAAAA) begin
         n_fail++;
         $display("FAIL skid_full got rdy %b/%b data %h exp rdy 0 data aaaa", in_ready0, in_ready1, out_data0);
      end
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 2'd0, dz, 1'b0);
         n_cmp++;
         if (out_data0 !== 64'hAAAA || out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin
            n_fail++;
            $display("FAIL skid_stall%0d got data %h vld %b rdy %b exp aaaa 1 0", i, out_data0, out_valid0, in_ready0);
         end
      end
      apply(1'b1, 2'd0, dz, 1'b1);
      n_cmp++;
      if (out_data0 !== 64'hBBBB || in_ready0 !== 1'b1) begin
         n_fail++;
         $display("FAIL skid_y got data %h rdy %b exp bbbb 1", out_data0, in_ready0);
      end
      apply(1'b1, 2'd0, dz, 1'b1);
      n_cmp++;
      if (out_data0 !== 64'hCCCC || out_valid0 !== 1'b1) begin
         n_fail++;
         $display("FAIL skid_z got data %h vld %b exp cccc 1", out_data0, out_valid0);
      end
      apply(1'b0, 2'd0, dz, 1'b1);
      n_cmp++;
      if (out_valid0 !== 1'b0) begin
         n_fail++;
         $display("FAIL skid_end got vld %b exp 0", out_valid0);
      end
   endtask

   task automatic test_random();
      int   accepted, cyc;
      logic v, r, exp_rdy, exp_vld;
      accepted = 0;
      cyc      = 0;
      do_reset();
      while (accepted < 1000 && cyc < 8000) begin
         exp_rdy = (q0.size() < 2);
         exp_vld = (q0.size() > 0);
         n_cmp++;
         if (in_ready0 !== exp_rdy || in_ready1 !== exp_rdy || out_valid0 !== exp_vld || out_valid1 !== exp_vld) begin
            n_fail++;
            $display("FAIL rnd_hs cyc %0d got rdy %b/%b vld %b/%b exp rdy %b vld %b", cyc, in_ready0, in_ready1, out_valid0, out_valid1, exp_rdy, exp_vld);
         end
         if (exp_vld) begin
            n_cmp++;
            if ({out_data0, out_err0} !== q0[0] || {out_data1, out_err1} !== q1[0]) begin
               n_fail++;
               $display("FAIL rnd_data cyc %0d got %h/%b %h/%b exp %h/%b %h/%b", cyc, out_data0, out_err0, out_data1, out_err1,
                        q0[0].data, q0[0].err, q1[0].data, q1[0].err);
            end
         end
         n_cmp++;
         if (err_count0 !== 16'(m_errs) || err_count1 !== 16'(m_errs)) begin
            n_fail++;
            $display("FAIL rnd_cnt cyc %0d got %0d/%0d exp %0d", cyc, err_count0, err_count1, m_errs);
         end
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 1) != 0);
         if (v && exp_rdy) accepted++;
         apply(v, 2'($urandom_range(0, 3)), rand_data(), r);
         cyc++;
      end
      n_cmp++;
      if (accepted < 1000) begin
         n_fail++;
         $display("FAIL rnd_budget got %0d beats exp 1000", accepted);
      end
      for (int i = 0; i < 4; i++) apply(1'b0, 2'd0, '0, 1'b1);
      n_cmp++;
      if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || in_ready0 !== 1'b1) begin
         n_fail++;
         $display("FAIL rnd_drain got vld %b/%b rdy %b exp 0/0 1", out_valid0, out_valid1, in_ready0);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 1; i <= 65540; i++) begin
         apply(1'b1, 2'd3, '0, 1'b1);
         if (i == 65534 || i == 65535) begin
            n_cmp++;
            if (err_count0 !== 16'(i) || err_count1 !== 16'(i)) begin
               n_fail++;
               $display("FAIL sat_edge%0d got %h/%h exp %h", i, err_count0, err_count1, 16'(i));
            end
         end
      end
      n_cmp++;
      if (err_count0 !== 16'hFFFF || err_count1 !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL sat_stick got %h/%h exp ffff", err_count0, err_count1);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      apply(1'b1, 2'd3, D_ABC, 1'b0);
      apply(1'b1, 2'd0, D_ABC, 1'b0);
      n_cmp++;
      if (in_ready0 !== 1'b0 || err_count0 !== 16'd1 || out_valid0 !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pre got rdy %b cnt %0d vld %b exp 0 1 1", in_ready0, err_count0, out_valid0);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || err_count0 !== 16'd0 || err_count1 !== 16'd0 || in_ready0 !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_async got vld %b/%b cnt %0d/%0d rdy %b exp 0/0 0/0 1", out_valid0, out_valid1, err_count0, err_count1, in_ready0);
      end
      n_cmp++;
      if (out_data0 !== '0 || out_data1 !== '0 || out_err0 !== 1'b0 || out_err1 !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_vals got %h/%h err %b/%b exp 0", out_data0, out_data1, out_err0, out_err1);
      end
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      apply(1'b1, 2'd2, D_ABC, 1'b1);
      n_cmp++;
      if (out_valid0 !== 1'b1 || out_data0 !== 64'h3333 || out_data1 !== 64'h3333 || out_err0 !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_first got vld %b data %h/%h err %b exp 1 3333 0", out_valid0, out_data0, out_data1, out_err0);
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_basic();
      test_illegal();
      test_back_to_back_skid();
      test_random();
      test_saturation();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/operand_sel_pipe.md
Name: operand_sel_pipe

Overview:
- Parametrised successor to the combinational 3:1 operand mux: an N-way operand select registered behind a valid/ready handshake.
- Uses a 2-entry skid buffer so full throughput holds under backpressure.
- Replaces the X output on an illegal select with defined data, an error flag and a saturating error counter.
- Sits between the forwarding/hazard logic and the ALU/branch operand inputs of the pipelined datapath.

Parameters:
- WIDTH, 64: data width of each input and of the output.
- NUM_IN, 3: number of selectable inputs, 2..16.
- SEL_W, $clog2(NUM_IN): width of the select field; derived, never overridden.
- INVALID_HOLD, 0: on an illegal select, 0 = emit all-zero data; 1 = emit the last legally selected data.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH]
- in_sel  in  SEL_W  select index
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- out_data  out  WIDTH  selected operand
- out_err  out  1  beat was produced from an illegal select
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts the output beat
- err_count  out  16  saturating count of accepted illegal-select beats

Behaviour:
- Reset (async assert, sync release):
  - state = EMPTY; out_valid = 0; out_data = 0; out_err = 0; err_count = 0.
  - Last-good register = 0; skid register = 0.
  - in_ready = 1 while in reset.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_data and in_sel are sampled only on input accept.
- Selection at accept:
  - Legal sel (< NUM_IN): data = input[sel], err = 0, last-good <= data.
  - Illegal sel (>= NUM_IN; only possible when NUM_IN is not a power of 2): data = 0 if INVALID_HOLD = 0, else the current last-good value; err = 1; last-good is unchanged; err_count += 1, saturating at 16'hFFFF.
- Storage: the output register (OUT) plus one skid register (SKID). Each stores {data, err}.
- State machine:
  - EMPTY: out_valid = 0, in_ready = 1. Accept -> load OUT -> ONE.
  - ONE: out_valid = 1, in_ready = 1.
    - Accept and transfer -> load OUT with the new beat, stay ONE.
    - Accept without transfer -> load SKID -> TWO.
    - Transfer without accept -> EMPTY.
    - Neither -> hold.
  - TWO: out_valid = 1, in_ready = 0.
    - Transfer -> OUT <= SKID -> ONE.
    - No transfer -> hold.
- in_ready is driven only from the state register, with no combinational path from out_ready.
- Latency: 1 cycle from accept to out_valid when the block is EMPTY.
- Throughput: 1 beat/cycle while out_ready = 1.
- Ordering: strictly FIFO. A beat is never dropped or duplicated.
- out_data and out_err are stable while out_valid = 1 and out_ready = 0.
- Reset mid-operation: both entries are discarded immediately, all outputs return to their reset values, and err_count is cleared.

Test Plan:
- Basic select, NUM_IN = 3, WIDTH = 64: inputs {A, B, C} = {64'h1111, 64'h2222, 64'h3333}; sel = 0, 1, 2 on consecutive cycles with out_ready = 1 -> out_data = 1111, 2222, 3333 one cycle later each; out_err = 0; back-to-back out_valid.
- Illegal select, INVALID_HOLD = 0: sel = 3 -> out_data = 0, out_err = 1, err_count = 1.
- Illegal select, INVALID_HOLD = 1: sel = 1 then sel = 3 -> second beat out_data = 2222 with out_err = 1.
- Backpressure/skid: out_ready = 0 and send beats X, Y -> after Y, in_ready = 0 and a third beat Z is not accepted. Raise out_ready -> X, Y, Z are delivered in order; out_data holds X throughout the stall.
- Simultaneous accept and transfer in ONE, with a random out_ready pattern over 1000 beats -> the scoreboard matches the input order exactly; no loss or duplicates; in_ready never 0 outside TWO.
- Counter saturation: force 65540 illegal beats -> err_count sticks at 16'hFFFF.
- Reset mid-operation: reset in TWO -> out_valid = 0 and err_count = 0 asynchronously; the first post-reset beat is delivered with 1-cycle latency.
